ncl_wavefront_injector: RTL and testbench

//   Clocked-to-NCL bridge feeding the dual-rail ripple/pipelined adder chain.

---
 rtl/ncl_wavefront_injector_if.sv | 27 ++
 rtl/ncl_wavefront_injector.sv | 131 +++++++++++++
 tb/tb_ncl_wavefront_injector.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ncl_wavefront_injector_if.sv
// Upstream operand handshake into the NCL wavefront injector.
// The producer of operand words uses master; the injector uses slave.
interface ncl_wavefront_injector_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_cin,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_cin,
        output in_ready
    );
endinterface

// File: rtl/ncl_wavefront_injector.sv
// Clocked-to-NCL bridge: encodes binary operands to dual-rail and alternates
// DATA / NULL wavefronts into the adder, paced by its synchronized acknowledge.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_NULL  | rails NULL; accept a word once the adder requests data
//   S_DATA  | rails hold DATA; wait for the adder to request NULL
//   S_NWAIT | rails NULL again; wait for the adder to request data (wave done)
module ncl_wavefront_injector #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    ncl_wavefront_injector_if.slave  up,
    output logic [2*WIDTH-1:0]       a_dr,
    output logic [2*WIDTH-1:0]       b_dr,
    output logic [1:0]               cin_dr,
    input  logic                     ko,
    output logic [15:0]              wave_count,
    output logic                     err_timeout
);
    localparam int            TW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_NULL  = 2'd0,
        S_DATA  = 2'd1,
        S_NWAIT = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] ko_sync;
    logic                   ko_s;
    logic                   accept;
    logic                   go_null;
    logic                   wave_done;
    logic                   waiting;
    logic [2*WIDTH-1:0]     enc_a;
    logic [2*WIDTH-1:0]     enc_b;
    logic [TW-1:0]          timer;

    always_ff @(posedge clk) begin
        if (rst) begin
            ko_sync <= '0;
        end else begin
            ko_sync <= {ko_sync[SYNC_STAGES-2:0], ko};
        end
    end

    assign ko_s = ko_sync[SYNC_STAGES-1];

    // Dual-rail encoding: logic 1 drives the upper rail, logic 0 the lower.
    always_comb begin
        enc_a = '0;
        enc_b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            enc_a[2*i +: 2] = {up.in_a[i], ~up.in_a[i]};
            enc_b[2*i +: 2] = {up.in_b[i], ~up.in_b[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_NULL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_NULL:  if (up.in_valid && ko_s) state_nxt = S_DATA;
            S_DATA:  if (!ko_s)               state_nxt = S_NWAIT;
            S_NWAIT: if (ko_s)                state_nxt = S_NULL;
            default:                          state_nxt = S_NULL;
        endcase
    end

    always_comb begin
        up.in_ready = (state == S_NULL) && ko_s;
        accept      = (state == S_NULL) && ko_s && up.in_valid;
        go_null     = (state == S_DATA) && !ko_s;
        wave_done   = (state == S_NWAIT) && ko_s;
        waiting     = (state == S_DATA) || (state == S_NWAIT);
    end

    // All rails are registered together so a wavefront lands on one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_dr   <= '0;
            b_dr   <= '0;
            cin_dr <= 2'b00;
        end else if (accept) begin
            a_dr   <= enc_a;
            b_dr   <= enc_b;
            cin_dr <= {up.in_cin, ~up.in_cin};
        end else if (go_null) begin
            a_dr   <= '0;
            b_dr   <= '0;
            cin_dr <= 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wave_count <= 16'd0;
        end else if (wave_done) begin
            wave_count <= wave_count + 16'd1;
        end
    end

    // Down-counter reloaded on each phase change; reaching zero in a wait
    // phase means the adder has stalled for TIMEOUT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer       <= '0;
            err_timeout <= 1'b0;
        end else if (state_nxt != state) begin
            timer <= TIMER_LOAD;
        end else if (waiting && (timer != '0)) begin
            timer <= timer - TW'(1);
            if (timer == TW'(1)) begin
                err_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ncl_wavefront_injector.sv
// Self-checking bench for ncl_wavefront_injector: directed phase timing plus
// randomized words against a dual-rail adder model and an expected-word list.
module tb_ncl_wavefront_injector;
    localparam int W     = 8;
    localparam int SYNC  = 2;
    localparam int TMO   = 20;
    localparam int NPAIR = 2*W + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           ko;
    logic           ko_man;
    logic           ko_auto;
    logic           auto_ko;
    logic           mon_en;
    logic [2*W-1:0] a_dr;
    logic [2*W-1:0] b_dr;
    logic [1:0]     cin_dr;
    logic [15:0]    wave_count;
    logic           err_timeout;

    logic [33:0]    exp_arr [0:127];
    int             n_push = 0;
    int             n_pop  = 0;
    int             n_cmp  = 0;
    int             n_bad  = 0;

    ncl_wavefront_injector_if #(.WIDTH(W)) up_if ();

    assign ko = auto_ko ? ko_auto : ko_man;

    ncl_wavefront_injector #(
        .WIDTH       (W),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .up          (up_if),
        .a_dr        (a_dr),
        .b_dr        (b_dr),
        .cin_dr      (cin_dr),
        .ko          (ko),
        .wave_count  (wave_count),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoding as arithmetic: bit value v contributes (v+1) << 2i.
    function automatic logic [2*W-1:0] enc(input logic [W-1:0] x);
        longint unsigned v = 0;
        for (int i = 0; i < W; i++) begin
            v += (x[i] ? 64'd2 : 64'd1) << (2*i);
        end
        return v[2*W-1:0];
    endfunction

    function automatic int pairs_eq(input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                                    input logic [1:0] c, input logic [1:0] p);
        int n = (c == p) ? 1 : 0;
        for (int i = 0; i < W; i++) begin
            if (a[2*i +: 2] == p) n++;
            if (b[2*i +: 2] == p) n++;
        end
        return n;
    endfunction

    // Adder model: acknowledges a complete DATA or NULL wavefront after 3 or 7 cycles.
    initial begin : adder_model
        int wait_cnt = 0;
        int n00;
        ko_auto = 1'b1;
        forever begin
            @(negedge clk);
            if (!auto_ko) begin
                wait_cnt = 0;
                ko_auto  = 1'b1;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) ko_auto = ~ko_auto;
            end else begin
                n00 = pairs_eq(a_dr, b_dr, cin_dr, 2'b00);
                if ((ko_auto && n00 == 0) || (!ko_auto && n00 == NPAIR))
                    wait_cnt = ($urandom_range(0, 1) == 1) ? 7 : 3;
            end
        end
    end

    initial begin : monitor
        logic [33:0] prev = '0;
        logic        prev_data = 1'b0;
        int          n00;
        logic        is_data;
        logic        is_null;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                n00     = pairs_eq(a_dr, b_dr, cin_dr, 2'b00);
                is_null = (n00 == NPAIR);
                is_data = (n00 == 0);
                chk("no_rail_11", pairs_eq(a_dr, b_dr, cin_dr, 2'b11), 0);
                chk("wavefront_complete", is_null || is_data, 1);
                if (is_data) begin
                    chk("ready_during_data", up_if.in_ready, 0);
                    if (prev_data) begin
                        chk("data_held", {a_dr, b_dr, cin_dr}, prev);
                    end else begin
                        chk("sb_has_entry", n_pop < n_push, 1);
                        chk("data_word", {a_dr, b_dr, cin_dr}, exp_arr[n_pop[6:0]]);
                        n_pop++;
                    end
                end
                prev      = {a_dr, b_dr, cin_dr};
                prev_data = is_data;
            end else begin
                prev_data = 1'b0;
            end
        end
    end

    task automatic run_wave(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int t = 0;
        up_if.in_a     = a;
        up_if.in_b     = b;
        up_if.in_cin   = c;
        up_if.in_valid = 1'b1;
        while (!up_if.in_ready && t < 50) begin @(negedge clk); t++; end
        chk("wave_accept_in_time", t < 50, 1);
        @(negedge clk);
        up_if.in_valid = 1'b0;
        chk("wave_a", a_dr, enc(a));
        ko_man = 1'b0;
        t = 0;
        while (a_dr != '0 && t < 50) begin @(negedge clk); t++; end
        chk("wave_null_in_time", t < 50, 1);
        ko_man = 1'b1;
        t = 0;
        while (!up_if.in_ready && t < 50) begin @(negedge clk); t++; end
        chk("wave_ready_in_time", t < 50, 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int         n;
        int         t;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic       rc;

        rst            = 1'b1;
        ko_man         = 1'b1;
        auto_ko        = 1'b0;
        mon_en         = 1'b0;
        up_if.in_valid = 1'b0;
        up_if.in_a     = '0;
        up_if.in_b     = '0;
        up_if.in_cin   = 1'b0;

        // Reset state and ready latency after release with ko held high.
        repeat (3) @(negedge clk);
        chk("rst_ready", up_if.in_ready, 0);
        chk("rst_a_dr", a_dr, 0);
        chk("rst_b_dr", b_dr, 0);
        chk("rst_cin_dr", cin_dr, 0);
        chk("rst_wave_count", wave_count, 0);
        chk("rst_err", err_timeout, 0);
        rst = 1'b0;
        n = 0;
        while (!up_if.in_ready && n < 20) begin @(negedge clk); n++; end
        chk("ready_latency", n, SYNC);
        chk("idle_a_null", a_dr, 0);

        // Fixed vector: one-cycle latency, hold until ko falls, then NULL and count.
        up_if.in_a     = 8'hA5;
        up_if.in_b     = 8'h3C;
        up_if.in_cin   = 1'b1;
        up_if.in_valid = 1'b1;
        @(negedge clk);
        up_if.in_valid = 1'b0;
        chk("fix_a_dr", a_dr, 16'h9966);
        chk("fix_b_dr", b_dr, 16'h5AA5);
        chk("fix_cin_dr", cin_dr, 2'b10);
        chk("fix_ready_low", up_if.in_ready, 0);
        repeat (5) @(negedge clk);
        chk("fix_hold_a", a_dr, 16'h9966);
        ko_man = 1'b0;
        repeat (2) @(negedge clk);
        chk("fix_null_not_yet", a_dr, 16'h9966);
        @(negedge clk);
        chk("fix_null_a", a_dr, 0);
        chk("fix_null_b", b_dr, 0);
        chk("fix_null_cin", cin_dr, 0);
        ko_man = 1'b1;
        repeat (2) @(negedge clk);
        chk("fix_wc_not_yet", wave_count, 0);
        @(negedge clk);
        chk("fix_wave_count", wave_count, 1);
        chk("fix_ready_back", up_if.in_ready, 1);

        // 100 random words against the adder model.
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        auto_ko = 1'b1;
        mon_en  = 1'b1;
        for (int w = 0; w < 100; w++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra             = W'($urandom);
            rb             = W'($urandom);
            rc             = 1'($urandom_range(0, 1));
            up_if.in_a     = ra;
            up_if.in_b     = rb;
            up_if.in_cin   = rc;
            up_if.in_valid = 1'b1;
            t = 0;
            while (!up_if.in_ready && t < 100) begin @(negedge clk); t++; end
            chk("rand_accept_in_time", t < 100, 1);
            exp_arr[n_push[6:0]] = {enc(ra), enc(rb), rc ? 2'b10 : 2'b01};
            n_push++;
            @(negedge clk);
            up_if.in_valid = 1'b0;
        end
        t = 0;
        while (wave_count != 16'd100 && t < 300) begin @(negedge clk); t++; end
        chk("rand_wave_count", wave_count, 100);
        chk("rand_words_seen", n_pop, 100);
        chk("rand_no_timeout", err_timeout, 0);
        mon_en  = 1'b0;
        auto_ko = 1'b0;
        @(negedge clk);

        // Wrap of the wave counter.
        force dut.wave_count = 16'hFFFF;
        @(negedge clk);
        release dut.wave_count;
        run_wave(8'h0F, 8'hF0, 1'b0);
        chk("wave_count_wrap", wave_count, 0);

        // Timeout: ko stuck high while DATA is shown.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        t = 0;
        while (!up_if.in_ready && t < 20) begin @(negedge clk); t++; end
        ra             = 8'h5A;
        up_if.in_a     = ra;
        up_if.in_b     = 8'hC3;
        up_if.in_cin   = 1'b0;
        up_if.in_valid = 1'b1;
        @(negedge clk);
        up_if.in_valid = 1'b0;
        chk("to_data_a", a_dr, enc(ra));
        chk("to_err_start", err_timeout, 0);
        repeat (19) @(negedge clk);
        chk("to_err_cycle19", err_timeout, 0);
        @(negedge clk);
        chk("to_err_cycle20", err_timeout, 1);
        repeat (10) @(negedge clk);
        chk("to_err_sticky", err_timeout, 1);
        chk("to_data_held", a_dr, enc(ra));
        chk("to_cin_held", cin_dr, 2'b01);

        // Reset while DATA is shown, then no accept until ko returns high.
        rst    = 1'b1;
        ko_man = 1'b0;
        @(negedge clk);
        chk("rstd_a_null", a_dr, 0);
        chk("rstd_b_null", b_dr, 0);
        chk("rstd_cin_null", cin_dr, 0);
        chk("rstd_err_clear", err_timeout, 0);
        rst            = 1'b0;
        ra             = 8'h81;
        up_if.in_a     = ra;
        up_if.in_b     = 8'h7E;
        up_if.in_cin   = 1'b1;
        up_if.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rstd_ready_low", up_if.in_ready, 0);
            chk("rstd_no_accept", a_dr, 0);
        end
        ko_man = 1'b1;
        n = 0;
        while (!up_if.in_ready && n < 20) begin @(negedge clk); n++; end
        chk("rstd_ready_latency", n, SYNC);
        @(negedge clk);
        up_if.in_valid = 1'b0;
        chk("rstd_held_word_a", a_dr, enc(ra));
        chk("rstd_held_word_b", b_dr, enc(8'h7E));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
